// File: rtl/unidade_mul_div_if.sv
// Operand/result bundle between execute-stage control and the iterative
// multiply/divide unit.
interface unidade_mul_div_if #(parameter int LARGURA = 32);
  logic               inicio;
  logic               operacao;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic [LARGURA-1:0] resultado;
  logic [LARGURA-1:0] complemento;
  logic               ocupado;
  logic               pronto;
  logic               div_zero;

  modport master (
    output inicio, operacao, A, B,
    input  resultado, complemento, ocupado, pronto, div_zero
  );

  modport slave (
    input  inicio, operacao, A, B,
    output resultado, complemento, ocupado, pronto, div_zero
  );
endinterface

// File: rtl/unidade_mul_div.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// Fixed ITERACOES-cycle sequence, with an immediate result for divide-by-zero.
module unidade_mul_div #(
  parameter int LARGURA   = 32,
  parameter int ITERACOES = 32
) (
  input  logic              clock,
  input  logic              reset,
  unidade_mul_div_if.slave  bus
);
  localparam int CW = $clog2(ITERACOES);
  localparam logic [CW-1:0] ULTIMO = CW'(ITERACOES - 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t              estado;
  logic                 op_r;
  logic [LARGURA-1:0]   b_r;
  logic [CW-1:0]        cnt;
  logic [2*LARGURA-1:0] acc;
  logic [LARGURA-1:0]   resto;
  logic [LARGURA-1:0]   quoc;
  logic [LARGURA-1:0]   resultado_r, complemento_r;
  logic                 ocupado_r, pronto_r, div_zero_r;

  logic [LARGURA:0]     soma;
  logic [2*LARGURA-1:0] acc_nx;
  logic [LARGURA:0]     desl, dif;
  logic [LARGURA-1:0]   resto_nx, quoc_nx;

  always_comb begin
    soma   = {1'b0, acc[2*LARGURA-1:LARGURA]} + (acc[0] ? {1'b0, b_r} : '0);
    acc_nx = {soma, acc[LARGURA-1:1]};
    desl   = {resto, quoc[LARGURA-1]};
    // Partial remainder stays below 2*B, so the difference's top bit is a clean borrow.
    dif    = desl - {1'b0, b_r};
    if (!dif[LARGURA]) begin
      resto_nx = dif[LARGURA-1:0];
      quoc_nx  = {quoc[LARGURA-2:0], 1'b1};
    end else begin
      resto_nx = desl[LARGURA-1:0];
      quoc_nx  = {quoc[LARGURA-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= OCIOSO;
      op_r          <= 1'b0;
      b_r           <= '0;
      cnt           <= '0;
      acc           <= '0;
      resto         <= '0;
      quoc          <= '0;
      resultado_r   <= '0;
      complemento_r <= '0;
      ocupado_r     <= 1'b0;
      pronto_r      <= 1'b0;
      div_zero_r    <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, FIM: begin
          if (bus.inicio) begin
            op_r  <= bus.operacao;
            b_r   <= bus.B;
            cnt   <= '0;
            acc   <= {{LARGURA{1'b0}}, bus.A};
            resto <= '0;
            quoc  <= bus.A;
            if (bus.operacao && bus.B == '0) begin
              estado        <= FIM;
              ocupado_r     <= 1'b0;
              pronto_r      <= 1'b1;
              resultado_r   <= '1;
              complemento_r <= bus.A;
              div_zero_r    <= 1'b1;
            end else begin
              estado    <= CALCULA;
              ocupado_r <= 1'b1;
              pronto_r  <= 1'b0;
            end
          end else begin
            estado   <= OCIOSO;
            pronto_r <= 1'b0;
          end
        end
        CALCULA: begin
          acc   <= acc_nx;
          resto <= resto_nx;
          quoc  <= quoc_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == ULTIMO) begin
            estado        <= FIM;
            ocupado_r     <= 1'b0;
            pronto_r      <= 1'b1;
            div_zero_r    <= 1'b0;
            resultado_r   <= op_r ? quoc_nx  : acc_nx[LARGURA-1:0];
            complemento_r <= op_r ? resto_nx : acc_nx[2*LARGURA-1:LARGURA];
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.resultado   = resultado_r;
  assign bus.complemento = complemento_r;
  assign bus.ocupado     = ocupado_r;
  assign bus.pronto      = pronto_r;
  assign bus.div_zero    = div_zero_r;
endmodule

// File: tb/tb_unidade_mul_div.sv
// Self-checking bench for unidade_mul_div: vector table, random ops against an
// arithmetic reference model, and hand-written abort/ignore/back-to-back sequences.
module tb_unidade_mul_div;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unidade_mul_div_if #(.LARGURA(32)) bus ();
  unidade_mul_div #(.LARGURA(32), .ITERACOES(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        op;
    logic [31:0] a, b;
    logic [31:0] res, comp;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nome, act, exp);
  endtask

  task automatic modelo(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] comp,
                        output logic dz, output int lat);
    logic [63:0] p;
    if (!op) begin
      p = 64'(a) * 64'(b);
      res = p[31:0]; comp = p[63:32]; dz = 1'b0; lat = 33;
    end else if (b == 0) begin
      res = 32'hFFFFFFFF; comp = a; dz = 1'b1; lat = 1;
    end else begin
      res = a / b; comp = a % b; dz = 1'b0; lat = 33;
    end
  endtask

  // Called at a negedge: presents an op with inicio high for exactly one edge.
  task automatic inicia(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.operacao = op; bus.A = a; bus.B = b; bus.inicio = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;
  endtask

  // Entered at the negedge numbered 'ini' after the accepting edge.
  task automatic espera(input int ini, output int lat, output int busy);
    lat = ini; busy = 0;
    while (!bus.pronto && lat < 100) begin
      if (bus.ocupado) busy++;
      @(negedge clock);
      lat++;
    end
    if (!bus.pronto) chk("timeout_pronto", 64'(bus.pronto), 64'd1);
  endtask

  task automatic executa(input string nome, input vec_t v);
    int lat, busy;
    logic [31:0] r0, c0;
    inicia(v.op, v.a, v.b);
    espera(1, lat, busy);
    chk({nome, "_lat"}, 64'(lat), 64'(v.lat));
    chk({nome, "_ocupado_ciclos"}, 64'(busy), 64'(v.lat - 1));
    chk({nome, "_resultado"}, 64'(bus.resultado), 64'(v.res));
    chk({nome, "_complemento"}, 64'(bus.complemento), 64'(v.comp));
    chk({nome, "_div_zero"}, 64'(bus.div_zero), 64'(v.dz));
    r0 = bus.resultado; c0 = bus.complemento;
    @(negedge clock);
    chk({nome, "_pronto_pulso"}, 64'(bus.pronto), 64'd0);
    chk({nome, "_hold"}, {bus.resultado, bus.complemento}, {r0, c0});
  endtask

  initial begin
    vec_t tab[$];
    vec_t v;
    int lat, busy, vi;
    logic seen;

    bus.inicio = 1'b0; bus.operacao = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("reset_resultado", 64'(bus.resultado), 64'd0);
    chk("reset_complemento", 64'(bus.complemento), 64'd0);
    chk("reset_flags", {61'd0, bus.ocupado, bus.pronto, bus.div_zero}, 64'd0);
    repeat (4) @(negedge clock);
    chk("idle_estavel", {bus.resultado, bus.complemento}, 64'd0);
    chk("idle_flags", {61'd0, bus.ocupado, bus.pronto, bus.div_zero}, 64'd0);

    tab.push_back('{1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 33});
    tab.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33});
    tab.push_back('{1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    tab.push_back('{1'b1, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33});
    tab.push_back('{1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1});
    tab.push_back('{1'b0, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 33});
    tab.push_back('{1'b0, 32'd123, 32'd0, 32'd0, 32'd0, 1'b0, 33});
    tab.push_back('{1'b1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33});
    for (int i = 0; i < tab.size(); i++) executa($sformatf("vec%0d", i), tab[i]);

    for (int i = 0; i < 20; i++) begin
      v.op = 1'($urandom_range(0, 1));
      v.a  = $urandom;
      vi   = $urandom_range(0, 9);
      v.b  = (vi == 0) ? 32'd0 : (vi < 4) ? 32'($urandom_range(1, 255)) : $urandom;
      modelo(v.op, v.a, v.b, v.res, v.comp, v.dz, v.lat);
      executa($sformatf("rnd%0d", i), v);
    end

    // inicio during iteration 10 must be ignored
    inicia(1'b0, 32'd1000, 32'd3000);
    repeat (10) @(negedge clock);
    bus.operacao = 1'b1; bus.A = 32'd55; bus.B = 32'd0; bus.inicio = 1'b1;
    @(negedge clock);
    bus.inicio = 1'b0;
    espera(12, lat, busy);
    chk("ignora_lat", 64'(lat), 64'd33);
    chk("ignora_resultado", {bus.complemento, bus.resultado}, 64'd3000000);
    chk("ignora_div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clock);

    // reset mid-operation aborts with no pronto
    inicia(1'b1, 32'd100, 32'd7);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_saidas", {bus.resultado, bus.complemento}, 64'd0);
    chk("abort_flags", {61'd0, bus.ocupado, bus.pronto, bus.div_zero}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      seen = seen | bus.pronto | bus.ocupado;
    end
    chk("abort_sem_pronto", 64'(seen), 64'd0);

    // inicio held through FIM: second op starts with no idle gap
    bus.operacao = 1'b0; bus.A = 32'd11; bus.B = 32'd13; bus.inicio = 1'b1;
    @(negedge clock);
    bus.operacao = 1'b1; bus.A = 32'd1000; bus.B = 32'd7;
    espera(1, lat, busy);
    chk("b2b_lat1", 64'(lat), 64'd33);
    chk("b2b_res1", {bus.complemento, bus.resultado}, 64'd143);
    @(negedge clock);
    bus.inicio = 1'b0;
    chk("b2b_transicao", {62'd0, bus.ocupado, bus.pronto}, 64'b10);
    espera(1, lat, busy);
    chk("b2b_lat2", 64'(lat), 64'd33);
    chk("b2b_res2", {bus.complemento, bus.resultado}, {32'd6, 32'd142});
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
